scytale_encryption: RTL and testbench

Transmit-side counterpart to the scytale decryption engine. It buffers a plaintext character stream until the terminator byte arrives. It then emits the scytale ciphertext, one character per cycle, in the order the decryption engine expects to consume. It sits on the `clk` system domain in the encryption path and feeds either a downstream decryption engine or the mux.

---
 rtl/scytale_encryption.sv | 155 +++++++++++++++
 tb/tb_scytale_encryption.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scytale_encryption.sv
// scytale_encryption
//   Collects a plaintext character stream until the terminator byte, then
//   emits the scytale ciphertext (column-major read of an M-row by N-column
//   grid) one character per cycle. Cells beyond the received text read as
//   0x00; received text beyond N*M is never emitted.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   data_i   plaintext character
//   valid_i  data_i valid this cycle (ignored while busy)
//   key_N    column count, sampled with the terminator
//   key_M    row count, sampled with the terminator
//   busy     ciphertext emission in progress
//   data_o   ciphertext character, 0 whenever valid_o is low
//   valid_o  data_o valid this cycle
//
// Build option
//   SCYTALE_ENC_TOKEN_ECHO_EN  when defined, a TERMINATOR byte follows the
//                              last ciphertext character (busy held high).
module scytale_encryption #(
    parameter int D_WIDTH       = 8,
    parameter int KEY_WIDTH     = 8,
    parameter int MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] TERMINATOR = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int AW = $clog2(MAX_NOF_CHARS);
    localparam int PW = 2 * KEY_WIDTH;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state;
    logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
    logic [CW-1:0]        count;
    logic [KEY_WIDTH-1:0] n_reg, m_reg;
    logic [KEY_WIDTH-1:0] row, col;
    logic [PW-1:0]        idx;
    logic [PW-1:0]        remaining;
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
    logic                 echo_done;
`endif

    logic [PW-1:0] prod;
    logic          store_char;
    logic          term_seen;

    assign prod       = PW'(key_N) * PW'(key_M);
    assign term_seen  = (state == IDLE) && valid_i && (data_i == TERMINATOR);
    assign store_char = (state == IDLE) && valid_i && (data_i != TERMINATOR)
                        && (count < CW'(MAX_NOF_CHARS));

    // Buffer read with padding for cells past the received text.
    function automatic logic [D_WIDTH-1:0] rd(input logic [PW-1:0] i);
        return (i < PW'(count)) ? mem[i[AW-1:0]] : '0;
    endfunction

    // Buffer contents need no reset; count qualifies every read.
    always_ff @(posedge clk) begin
        if (store_char)
            mem[count[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            valid_o   <= 1'b0;
            data_o    <= '0;
            n_reg     <= '0;
            m_reg     <= '0;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
            remaining <= '0;
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
            echo_done <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (store_char) begin
                        count <= count + CW'(1);
                    end else if (term_seen) begin
                        if (key_N == '0 || key_M == '0 || prod > PW'(MAX_NOF_CHARS)) begin
                            count <= '0;
                        end else begin
                            n_reg     <= key_N;
                            m_reg     <= key_M;
                            state     <= EMIT;
                            busy      <= 1'b1;
                            valid_o   <= 1'b1;
                            data_o    <= rd('0);
                            remaining <= prod - PW'(1);
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
                            echo_done <= 1'b0;
`endif
                            // Cell (0,0) goes out now; point at the next cell.
                            if (key_M == KEY_WIDTH'(1)) begin
                                row <= '0;
                                col <= KEY_WIDTH'(1);
                                idx <= PW'(1);
                            end else begin
                                row <= KEY_WIDTH'(1);
                                col <= '0;
                                idx <= PW'(key_N);
                            end
                        end
                    end
                end
                EMIT: begin
                    if (remaining != '0) begin
                        data_o    <= rd(idx);
                        remaining <= remaining - PW'(1);
                        // Step down a column by adding N; wrap to the next
                        // column head (index c+1) after the last row.
                        if (row == m_reg - KEY_WIDTH'(1)) begin
                            row <= '0;
                            col <= col + KEY_WIDTH'(1);
                            idx <= PW'(col) + PW'(1);
                        end else begin
                            row <= row + KEY_WIDTH'(1);
                            idx <= idx + PW'(n_reg);
                        end
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
                    end else if (!echo_done) begin
                        data_o    <= TERMINATOR;
                        echo_done <= 1'b1;
`endif
                    end else begin
                        state   <= IDLE;
                        count   <= '0;
                        busy    <= 1'b0;
                        valid_o <= 1'b0;
                        data_o  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scytale_encryption.sv
module tb_scytale_encryption;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic       busy;
    logic [7:0] data_o;
    logic       valid_o;

    int checks = 0;
    int errors = 0;

    scytale_encryption dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_N   (key_N),
        .key_M   (key_M),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            data_i  = s[i];
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    // Returns just after the terminator edge T, first ciphertext char visible.
    task automatic send_term(input logic [7:0] n, input logic [7:0] m);
        data_i  = 8'hFA;
        valid_i = 1'b1;
        key_N   = n;
        key_M   = m;
        step();
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset: busy=%b valid_o=%b data_o=%h, expected 0/0/00", busy, valid_o, data_o);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
    endtask

    // N=2 M=3; keys and input are scrambled during emission and must not matter.
    task automatic test_basic();
        logic [7:0] exp [6] = '{"A", "C", "E", "B", "D", "F"};
        send_str("ABCDEF");
        send_term(8'd2, 8'd3);
        key_N = 8'd0;
        key_M = 8'd0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (valid_o !== 1'b1 || busy !== 1'b1 || data_o !== exp[k]) begin
                errors++;
                $display("FAIL basic[%0d]: data_o=%h valid_o=%b busy=%b, expected %h/1/1", k, data_o, valid_o, busy, exp[k]);
            end
            data_i  = "Z";
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
        checks++;
        if (valid_o !== 1'b1 || busy !== 1'b1 || data_o !== 8'hFA) begin
            errors++;
            $display("FAIL basic_echo: data_o=%h valid_o=%b busy=%b, expected FA/1/1", data_o, valid_o, busy);
        end
        step();
`endif
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL basic_end: busy=%b valid_o=%b data_o=%h, expected 0/0/00", busy, valid_o, data_o);
        end
    endtask

    // N=3 M=2 with only four characters; leftover cells pad with 0x00.
    task automatic test_padding();
        logic [7:0] exp [6] = '{"A", "D", "B", 8'h00, "C", 8'h00};
        send_str("ABCD");
        send_term(8'd3, 8'd2);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (valid_o !== 1'b1 || busy !== 1'b1 || data_o !== exp[k]) begin
                errors++;
                $display("FAIL padding[%0d]: data_o=%h valid_o=%b busy=%b, expected %h/1/1", k, data_o, valid_o, busy, exp[k]);
            end
            step();
        end
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
        step();
`endif
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL padding_end: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
    endtask

    // N=2 M=2 with six characters; E and F are never emitted.
    task automatic test_truncation();
        logic [7:0] exp [4] = '{"A", "C", "B", "D"};
        send_str("ABCDEF");
        send_term(8'd2, 8'd2);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp[k]) begin
                errors++;
                $display("FAIL truncation[%0d]: data_o=%h valid_o=%b, expected %h/1", k, data_o, valid_o, exp[k]);
            end
            step();
        end
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
        checks++;
        if (data_o !== 8'hFA || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL truncation_echo: data_o=%h valid_o=%b, expected FA/1", data_o, valid_o);
        end
        step();
`endif
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL truncation_end: busy=%b valid_o=%b data_o=%h, expected 0/0/00", busy, valid_o, data_o);
        end
    endtask

    // N=0 discards the message; the next message starts right at T+1.
    task automatic test_invalid_keys();
        logic [7:0] exp [2] = '{"P", "Q"};
        send_str("XY");
        send_term(8'd0, 8'd5);
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_t1: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
        send_str("PQ");
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_quiet: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
        send_term(8'd1, 8'd2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid_o !== 1'b1 || busy !== 1'b1 || data_o !== exp[k]) begin
                errors++;
                $display("FAIL after_invalid[%0d]: data_o=%h valid_o=%b busy=%b, expected %h/1/1", k, data_o, valid_o, busy, exp[k]);
            end
            step();
        end
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
        step();
`endif
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL after_invalid_end: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
    endtask

    // Reset during emission after the first character, with input offered.
    task automatic test_reset_mid_emit();
        send_str("ABC");
        send_term(8'd1, 8'd3);
        checks++;
        if (valid_o !== 1'b1 || data_o !== "A") begin
            errors++;
            $display("FAIL rst_first: data_o=%h valid_o=%b, expected 41/1", data_o, valid_o);
        end
        rst     = 1'b1;
        data_i  = "Z";
        valid_i = 1'b1;
        step();
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
                errors++;
                $display("FAIL rst_quiet[%0d]: busy=%b valid_o=%b data_o=%h, expected 0/0/00", k, busy, valid_o, data_o);
            end
            step();
        end
        send_str("K");
        send_term(8'd1, 8'd1);
        checks++;
        if (valid_o !== 1'b1 || data_o !== "K") begin
            errors++;
            $display("FAIL rst_next: data_o=%h valid_o=%b, expected 4b/1", data_o, valid_o);
        end
        step();
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
        step();
`endif
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_end: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
    endtask

    // 52 characters (values 1..52) into a 50-deep buffer, N=10 M=5.
    task automatic test_saturation();
        logic [7:0] exp;
        int         bad;
        bad = 0;
        for (int i = 0; i < 52; i++) begin
            data_i  = 8'(i + 1);
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        send_term(8'd10, 8'd5);
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < 5; r++) begin
                exp = 8'(r * 10 + c + 1);
                checks++;
                if (valid_o !== 1'b1 || data_o !== exp) begin
                    errors++;
                    bad++;
                    if (bad < 5)
                        $display("FAIL saturation[c%0d r%0d]: data_o=%h valid_o=%b, expected %h/1", c, r, data_o, valid_o, exp);
                end
                step();
            end
        end
`ifdef SCYTALE_ENC_TOKEN_ECHO_EN
        step();
`endif
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL saturation_end: busy=%b valid_o=%b, expected 0/0", busy, valid_o);
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_i  = 8'h00;
        valid_i = 1'b0;
        key_N   = 8'd0;
        key_M   = 8'd0;
        test_reset();
        test_basic();
        test_padding();
        test_truncation();
        test_invalid_keys();
        test_reset_mid_emit();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
